// File: rtl/img_pkg.sv
// Shared sizing and state encoding for the MNIST image beat unpacker.
package img_pkg;

  localparam int unsigned BEAT_BITS    = 128;
  localparam int unsigned PIXEL_BITS   = 8;
  localparam int unsigned NUM_PIXELS   = 784;
  localparam int unsigned PIX_PER_BEAT = BEAT_BITS / PIXEL_BITS;
  localparam int unsigned NUM_BEATS    = NUM_PIXELS / PIX_PER_BEAT;

  typedef enum logic [1:0] {IDLE, FILL, LOAD, SHIFT} unpack_state_t;

endpackage

// File: rtl/img_beat_ram.sv
// 49x128 simple dual-port beat store: one write port, registered read port (block-RAM style).
module img_beat_ram
  import img_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [5:0]           waddr,
  input  logic [BEAT_BITS-1:0] wdata,
  input  logic [5:0]           raddr,
  output logic [BEAT_BITS-1:0] q
);

  logic [BEAT_BITS-1:0] mem [NUM_BEATS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    q <= mem[raddr];
  end

endmodule

// File: rtl/img_beat_unpacker.sv
// Captures one image as 49 SDRAM beats, then replays it one pixel per valid/ready handshake.
module img_beat_unpacker
  import img_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  beat_valid,
  input  logic [BEAT_BITS-1:0]  beat_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [PIXEL_BITS-1:0] pix_data,
  output logic [9:0]            pix_index,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam logic [5:0] LastBeat = 6'(NUM_BEATS - 1);
  localparam logic [3:0] LastByte = 4'(PIX_PER_BEAT - 1);

  unpack_state_t        state;
  logic [5:0]           wr_cnt;
  logic [5:0]           beat_cnt;
  logic [3:0]           byte_cnt;
  logic [BEAT_BITS-1:0] q;
  logic                 ram_we;

  // start wins over a coincident beat in FILL, so that beat is never written.
  assign ram_we = (state == FILL) && beat_valid && !start;

  img_beat_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_cnt),
    .wdata (beat_data),
    .raddr (beat_cnt),
    .q     (q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_cnt   <= '0;
      beat_cnt <= '0;
      byte_cnt <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && state != IDLE) begin
        // Abort: discard the partial image and start filling again.
        state    <= FILL;
        wr_cnt   <= '0;
        beat_cnt <= '0;
        byte_cnt <= '0;
        if (beat_valid && state != FILL) begin
          overrun <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state    <= FILL;
              wr_cnt   <= '0;
              beat_cnt <= '0;
              byte_cnt <= '0;
              overrun  <= beat_valid;
            end else if (beat_valid) begin
              overrun <= 1'b1;
            end
          end
          FILL: begin
            if (beat_valid) begin
              wr_cnt <= wr_cnt + 6'd1;
              if (wr_cnt == LastBeat) begin
                state    <= LOAD;
                beat_cnt <= '0;
                byte_cnt <= '0;
              end
            end
          end
          LOAD: begin
            state <= SHIFT;
            if (beat_valid) begin
              overrun <= 1'b1;
            end
          end
          SHIFT: begin
            if (beat_valid) begin
              overrun <= 1'b1;
            end
            if (pix_ready) begin
              if (byte_cnt == LastByte) begin
                byte_cnt <= '0;
                if (beat_cnt == LastBeat) begin
                  state    <= IDLE;
                  beat_cnt <= '0;
                  done     <= 1'b1;
                end else begin
                  state    <= LOAD;
                  beat_cnt <= beat_cnt + 6'd1;
                end
              end else begin
                byte_cnt <= byte_cnt + 4'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign pix_valid = (state == SHIFT);
  assign busy      = (state != IDLE);
  // Gated so pix_data reads 0 outside SHIFT even though q itself has no reset.
  assign pix_data  = pix_valid ? q[{byte_cnt, 3'b000} +: PIXEL_BITS] : '0;
  assign pix_index = {beat_cnt, byte_cnt};
  assign pix_last  = pix_valid && (beat_cnt == LastBeat) && (byte_cnt == LastByte);

endmodule
